// File: rtl/lut_cfg_pkg.sv
// Shared types and constants for the LUT programming front-end.
// LUT_CFG_READBACK_EN adds the VERIFY readback pass.
package lut_cfg_pkg;

    localparam int LUT_SIZE_DEF = 16;
    localparam int IDX_W        = $clog2(LUT_SIZE_DEF);
    localparam int HOLD_CYC_DEF = 1;
    localparam int HOLD_W       = 4;

    function automatic int cfg_latency(input int lut_size, input int hold_cyc);
`ifdef LUT_CFG_READBACK_EN
        return lut_size * (1 + hold_cyc) + 1 + 2 * lut_size;
`else
        return lut_size * (1 + hold_cyc) + 1;
`endif
    endfunction

    localparam int CFG_LATENCY_DEF = cfg_latency(LUT_SIZE_DEF, HOLD_CYC_DEF);

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
`ifdef LUT_CFG_READBACK_EN
        VERIFY,
`endif
        DONE
    } state_t;

endpackage

// File: rtl/lut_strobe_gen.sv
// Registered one-hot write strobe buses for the two LUTs.
// Only the selected LUT's bus ever carries the active bit.
module lut_strobe_gen
    import lut_cfg_pkg::*;
#(
    parameter int LUT_SIZE = LUT_SIZE_DEF,
    parameter int IW       = IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                sel,
    input  logic [IW-1:0]       idx,
    output logic [0:LUT_SIZE-1] write_in_1,
    output logic [0:LUT_SIZE-1] write_in_2
);

    logic [0:LUT_SIZE-1] oh;

    always_comb begin
        oh = '0;
        if (en) oh[idx] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            write_in_1 <= '0;
            write_in_2 <= '0;
        end else begin
            write_in_1 <= sel ? '0 : oh;
            write_in_2 <= sel ? oh : '0;
        end
    end

endmodule

// File: rtl/lut_cfg_writer.sv
// Serialises a truth-table word into per-cell write strobes for LUT_0/LUT_1.
// Define LUT_CFG_READBACK_EN to add a readback VERIFY pass and cfg_err.
module lut_cfg_writer
    import lut_cfg_pkg::*;
#(
    parameter int LUT_SIZE = LUT_SIZE_DEF,
    parameter int HOLD_CYC = HOLD_CYC_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic                cfg_sel,
    input  logic [LUT_SIZE-1:0] cfg_data,
    output logic [0:LUT_SIZE-1] write_in_1,
    output logic [0:LUT_SIZE-1] write_in_2,
    output logic                RnW_1,
    output logic                RnW_2,
    output logic                data_in_1,
    output logic                data_in_2,
    output logic                busy,
`ifdef LUT_CFG_READBACK_EN
    input  logic                out_lut_1,
    input  logic                out_lut_2,
    output logic                cfg_err,
`endif
    output logic                done
);

    localparam int                IW      = $clog2(LUT_SIZE);
    localparam logic [IW-1:0]     LAST    = IW'(LUT_SIZE - 1);
    localparam logic [HOLD_W-1:0] HOLD_LD = HOLD_W'(HOLD_CYC - 1);
`ifdef LUT_CFG_READBACK_EN
    localparam state_t POST_WR = VERIFY;
`else
    localparam state_t POST_WR = DONE;
`endif

    state_t              state, nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [HOLD_W-1:0]   hcnt, hcnt_nxt;
    logic [LUT_SIZE-1:0] data_reg;
    logic                sel_reg;
    logic                accept;
    logic                rnw_c, dat_c, en_c, done_c;

    assign accept = cfg_valid && cfg_ready;

    always_comb begin
        nxt      = state;
        idx_nxt  = idx;
        hcnt_nxt = hcnt;
        unique case (state)
            IDLE: if (accept) begin
                nxt     = SETUP;
                idx_nxt = '0;
            end
            SETUP: begin
                nxt      = STROBE;
                hcnt_nxt = HOLD_LD;
            end
            STROBE: begin
                if (hcnt != '0) begin
                    hcnt_nxt = hcnt - 1'b1;
                end else if (idx == LAST) begin
                    nxt      = POST_WR;
                    idx_nxt  = '0;
                    hcnt_nxt = '0;
                end else begin
                    nxt     = SETUP;
                    idx_nxt = idx + 1'b1;
                end
            end
`ifdef LUT_CFG_READBACK_EN
            // hcnt doubles as the 2-cycle read phase counter here
            VERIFY: begin
                if (hcnt == '0) begin
                    hcnt_nxt = 1;
                end else begin
                    hcnt_nxt = '0;
                    if (idx == LAST) nxt = DONE;
                    else idx_nxt = idx + 1'b1;
                end
            end
`endif
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            hcnt      <= '0;
            cfg_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            idx       <= idx_nxt;
            hcnt      <= hcnt_nxt;
            cfg_ready <= (nxt == IDLE);
            busy      <= (nxt != IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
            sel_reg  <= 1'b0;
        end else if (accept) begin
            data_reg <= cfg_data;
            sel_reg  <= cfg_sel;
        end
    end

    always_comb begin
        rnw_c  = 1'b1;
        dat_c  = 1'b0;
        en_c   = 1'b0;
        done_c = 1'b0;
        unique case (state)
            SETUP: begin
                rnw_c = 1'b0;
                dat_c = data_reg[idx];
            end
            STROBE: begin
                rnw_c = 1'b0;
                dat_c = data_reg[idx];
                en_c  = 1'b1;
            end
`ifdef LUT_CFG_READBACK_EN
            VERIFY: en_c = 1'b1;
`endif
            DONE:    done_c = 1'b1;
            default: ;
        endcase
    end

    // Pin registers follow the state by one cycle; unselected LUT stays idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            RnW_1     <= 1'b1;
            RnW_2     <= 1'b1;
            data_in_1 <= 1'b0;
            data_in_2 <= 1'b0;
            done      <= 1'b0;
        end else begin
            RnW_1     <= sel_reg ? 1'b1 : rnw_c;
            RnW_2     <= sel_reg ? rnw_c : 1'b1;
            data_in_1 <= ~sel_reg & dat_c;
            data_in_2 <= sel_reg & dat_c;
            done      <= done_c;
        end
    end

    lut_strobe_gen #(
        .LUT_SIZE (LUT_SIZE),
        .IW       (IW)
    ) u_strobe (
        .clk        (clk),
        .rst        (rst),
        .en         (en_c),
        .sel        (sel_reg),
        .idx        (idx),
        .write_in_1 (write_in_1),
        .write_in_2 (write_in_2)
    );

`ifdef LUT_CFG_READBACK_EN
    logic          chk_pend;
    logic [IW-1:0] chk_idx;

    // Sample lands at the end of the second cycle the read strobe is on the pins
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_pend <= 1'b0;
            chk_idx  <= '0;
            cfg_err  <= 1'b0;
        end else begin
            chk_pend <= (state == VERIFY) && (hcnt != '0);
            chk_idx  <= idx;
            if (accept)
                cfg_err <= 1'b0;
            else if (chk_pend &&
                     ((sel_reg ? out_lut_2 : out_lut_1) != data_reg[chk_idx]))
                cfg_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_lut_cfg_writer.sv
// Randomised self-checking bench for lut_cfg_writer (HOLD_CYC 1 and 3).
// Expected pin traces are derived from cell/phase arithmetic per cycle.
module tb_lut_cfg_writer;

    localparam int N  = 16;
    localparam int PW = 2 * N + 7;
`ifdef LUT_CFG_READBACK_EN
    localparam int RBC = 2 * N;
`else
    localparam int RBC = 0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         v1 = 1'b0, v3 = 1'b0, sel = 1'b0;
    logic [N-1:0] data = '0;

    logic         rdy1, bsy1, dn1, rnw11, rnw12, di11, di12;
    logic [0:N-1] w11, w12;
    logic         rdy3, bsy3, dn3, rnw31, rnw32, di31, di32;
    logic [0:N-1] w31, w32;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

`ifdef LUT_CFG_READBACK_EN
    logic         ol1, ol2, err1, err3;
    logic         stuck4 = 1'b0;
    logic [0:N-1] mem1 = '0, mem2 = '0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (w11[i] && !rnw11) mem1[i] <= di11;
            if (w12[i] && !rnw12) mem2[i] <= di12;
        end
    end

    function automatic logic lut_rd(input logic [0:N-1] m, input logic [0:N-1] w,
                                    input logic st);
        logic r = 1'b0;
        for (int i = 0; i < N; i++)
            if (w[i]) r = (st && i == 4) ? 1'b0 : m[i];
        return r;
    endfunction

    assign ol1 = lut_rd(mem1, w11, stuck4);
    assign ol2 = lut_rd(mem2, w12, stuck4);
`endif

    lut_cfg_writer #(.LUT_SIZE(N), .HOLD_CYC(1)) dut (
        .clk(clk), .rst(rst), .cfg_valid(v1), .cfg_ready(rdy1),
        .cfg_sel(sel), .cfg_data(data),
        .write_in_1(w11), .write_in_2(w12), .RnW_1(rnw11), .RnW_2(rnw12),
        .data_in_1(di11), .data_in_2(di12), .busy(bsy1),
`ifdef LUT_CFG_READBACK_EN
        .out_lut_1(ol1), .out_lut_2(ol2), .cfg_err(err1),
`endif
        .done(dn1)
    );

    lut_cfg_writer #(.LUT_SIZE(N), .HOLD_CYC(3)) dut3 (
        .clk(clk), .rst(rst), .cfg_valid(v3), .cfg_ready(rdy3),
        .cfg_sel(sel), .cfg_data(data),
        .write_in_1(w31), .write_in_2(w32), .RnW_1(rnw31), .RnW_2(rnw32),
        .data_in_1(di31), .data_in_2(di32), .busy(bsy3),
`ifdef LUT_CFG_READBACK_EN
        .out_lut_1(1'b0), .out_lut_2(1'b0), .cfg_err(err3),
`endif
        .done(dn3)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [PW-1:0] pins(input int u);
        if (u == 0) return {w11, w12, rnw11, rnw12, di11, di12, dn1, rdy1, bsy1};
        return {w31, w32, rnw31, rnw32, di31, di32, dn3, rdy3, bsy3};
    endfunction

    // k = cycles after the acceptance edge; each cell is 1 setup + h strobe cycles
    function automatic logic [PW-1:0] exp_pins(input logic s, input logic [N-1:0] d,
                                               input int h, input int k);
        logic [0:N-1] wr = '0;
        logic rnw = 1'b1, di = 1'b0, dn = 1'b0, rdy = 1'b0, bsy = 1'b1;
        int w   = N * (1 + h);
        int lat = w + RBC + 1;
        if (k >= 1 && k <= w) begin
            rnw = 1'b0;
            di  = d[(k - 1) / (1 + h)];
            if ((k - 1) % (1 + h) != 0) wr[(k - 1) / (1 + h)] = 1'b1;
        end else if (k > w && k < lat) begin
            wr[(k - w - 1) / 2] = 1'b1;
        end
        if (k == lat) begin
            dn = 1'b1; rdy = 1'b1; bsy = 1'b0;
        end
        if (s) return {{N{1'b0}}, wr, 1'b1, rnw, 1'b0, di, dn, rdy, bsy};
        return {wr, {N{1'b0}}, rnw, 1'b1, di, 1'b0, dn, rdy, bsy};
    endfunction

    task automatic accept(input int u, input logic s, input logic [N-1:0] d);
        int t = 0;
        sel  = s;
        data = d;
        if (u == 0) v1 = 1'b1; else v3 = 1'b1;
        while (!(u == 0 ? rdy1 : rdy3) && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) chk("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
        v1 = 1'b0;
        v3 = 1'b0;
    endtask

    task automatic track(input int u, input logic s, input logic [N-1:0] d,
                         input int stop_at, input bit nx, input logic ns,
                         input logic [N-1:0] nd);
        int h   = (u == 0) ? 1 : 3;
        int lat = N * (1 + h) + RBC + 1;
        for (int k = 0; k <= lat; k++) begin
            @(negedge clk);
            chk($sformatf("trace u%0d k=%0d", u, k), 64'(pins(u)), 64'(exp_pins(s, d, h, k)));
            if (k == stop_at) return;
            if (nx && k == 5) begin
                sel  = ns;
                data = nd;
                v1   = 1'b1;
            end
        end
    endtask

    localparam logic [PW-1:0] IDLE_P = {{(2 * N){1'b0}}, 7'b1100010};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ndone;
        logic s;
        logic [N-1:0] d;

        repeat (3) @(negedge clk);
        chk("reset_pins", 64'(pins(0)), 64'(IDLE_P));
        chk("reset_pins3", 64'(pins(1)), 64'(IDLE_P));
        rst = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", 64'(pins(0)), 64'(IDLE_P));
`ifdef LUT_CFG_READBACK_EN
        chk("err_reset", 64'(err1), 64'd0);
`endif

        accept(0, 1'b0, 16'hA5C3);
        track(0, 1'b0, 16'hA5C3, -1, 1'b1, 1'b1, 16'hFFFF);
`ifdef LUT_CFG_READBACK_EN
        chk("err_a5c3", 64'(err1), 64'd0);
`endif
        accept(0, 1'b1, 16'hFFFF);
        track(0, 1'b1, 16'hFFFF, -1, 1'b0, 1'b0, '0);
`ifdef LUT_CFG_READBACK_EN
        chk("err_ffff", 64'(err1), 64'd0);
`endif

        accept(0, 1'b0, 16'h3C5A);
        track(0, 1'b0, 16'h3C5A, 16, 1'b0, 1'b0, '0);
        #2 rst = 1'b1;
        #1;
        chk("rst_async", 64'(pins(0)), 64'(IDLE_P));
        @(negedge clk);
        rst   = 1'b0;
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (dn1) ndone++;
        end
        chk("no_done_after_rst", 64'(ndone), 64'd0);
        accept(0, 1'b0, 16'h0001);
        track(0, 1'b0, 16'h0001, -1, 1'b0, 1'b0, '0);

        accept(1, 1'b0, 16'h8000);
        track(1, 1'b0, 16'h8000, -1, 1'b0, 1'b0, '0);
`ifdef LUT_CFG_READBACK_EN
        chk("err3_zero_lut", 64'(err3), 64'd1);
`endif

        for (int r = 0; r < 4; r++) begin
            s = 1'($urandom_range(0, 1));
            d = N'($urandom);
            accept(0, s, d);
            track(0, s, d, -1, 1'b0, 1'b0, '0);
`ifdef LUT_CFG_READBACK_EN
            chk("err_rand", 64'(err1), 64'd0);
`endif
        end

`ifdef LUT_CFG_READBACK_EN
        stuck4 = 1'b1;
        accept(0, 1'b0, 16'hFFFF);
        track(0, 1'b0, 16'hFFFF, -1, 1'b0, 1'b0, '0);
        chk("err_stuck4", 64'(err1), 64'd1);
        stuck4 = 1'b0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
